bot_reg_sync: RTL and testbench

- Sits directly upstream of the robot icon renderer.
- Captures Rojobot location/info updates (upd_sysregs pulse) into shadow registers and commits them to the display-facing registers only at vertical-blank start, so the icon never tears mid-frame.
- Also generates the sprite animation frame column (ping-pong 0-1-2-1-0), advanced per video frame while the bot moves.
- Counts updates overwritten before commit.

---
 rtl/bot_reg_sync_pkg.sv | 23 ++
 rtl/bot_reg_sync_anim_seq.sv | 49 ++++
 rtl/bot_reg_sync.sv | 131 +++++++++++++
 tb/tb_bot_reg_sync.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bot_reg_sync_pkg.sv
// Shared display constants, BotInfo field layout and the update FSM encoding.
package bot_reg_sync_pkg;

    localparam int V_ACTIVE_DEF = 768;
    localparam int H_ACTIVE_DEF = 1024;

    // BotInfo field positions
    localparam int SPEED_HI  = 7;
    localparam int SPEED_LO  = 4;
    localparam int ORIENT_HI = 2;
    localparam int ORIENT_LO = 0;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // A bot with non-zero speed animates its sprite.
    function automatic logic bot_moving(input logic [7:0] info);
        return info[SPEED_HI:SPEED_LO] != 4'd0;
    endfunction

endpackage

// File: rtl/bot_reg_sync_anim_seq.sv
// Ping-pong sprite column counter (0-1-2-1-0...), stepped once every
// ANIM_FRAMES video frames while the bot is moving; parks at column 1
// when the bot stops.
module bot_reg_sync_anim_seq #(
    parameter int ANIM_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step_en,
    input  logic       moving,
    output logic [1:0] frame_col
);

    localparam logic [7:0] LAST_CNT = 8'(ANIM_FRAMES - 1);

    logic [7:0] anim_cnt;
    logic       dir_up;
    logic [1:0] next_col;

    // Candidate column one step along the current direction.
    always_comb begin
        next_col = dir_up ? frame_col + 2'd1 : frame_col - 2'd1;
    end

    // Frame-rate divider and direction bounce at the column limits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_col <= 2'd1;
            anim_cnt  <= 8'd0;
            dir_up    <= 1'b1;
        end else if (step_en) begin
            if (!moving) begin
                frame_col <= 2'd1;
                anim_cnt  <= 8'd0;
                dir_up    <= 1'b1;
            end else if (anim_cnt == LAST_CNT) begin
                anim_cnt  <= 8'd0;
                frame_col <= next_col;
                if (next_col == 2'd2)
                    dir_up <= 1'b0;
                else if (next_col == 2'd0)
                    dir_up <= 1'b1;
            end else begin
                anim_cnt <= anim_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/bot_reg_sync.sv
// Double-buffers Rojobot location/info updates so the display-facing
// registers only change at the start of vertical blank (no icon tearing),
// and drives the sprite animation column.
module bot_reg_sync
    import bot_reg_sync_pkg::*;
#(
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int ANIM_FRAMES = 8,
    parameter int LOC_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] pixel_row,
    input  logic               upd_sysregs,
    input  logic [LOC_W-1:0]   LocX_in,
    input  logic [LOC_W-1:0]   LocY_in,
    input  logic [7:0]         BotInfo_in,
    output logic signed [31:0] LocX_reg,
    output logic signed [31:0] LocY_reg,
    output logic [7:0]         BotInfo_reg,
    output logic signed [31:0] frame_col,
    output logic               commit_pulse,
    output logic [7:0]         overrun_cnt
);

    state_t           state;
    logic             in_vblank_d;
    logic             in_vblank;
    logic             vblank_start;
    logic [LOC_W-1:0] shadow_x;
    logic [LOC_W-1:0] shadow_y;
    logic [7:0]       shadow_info;
    logic [LOC_W-1:0] loc_x;
    logic [LOC_W-1:0] loc_y;
    logic [7:0]       info;
    logic             commit_now;
    logic [7:0]       commit_info;
    logic             moving;
    logic [1:0]       col;

    // Rising edge of "row is in vblank"; one cycle per frame.
    always_comb begin
        in_vblank    = pixel_row >= V_ACTIVE;
        vblank_start = in_vblank && !in_vblank_d;
    end

    // Row-in-vblank history; starts high so a reset inside vblank
    // cannot fabricate a vblank edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            in_vblank_d <= 1'b1;
        else
            in_vblank_d <= in_vblank;
    end

    // What (if anything) is committed this cycle; fresh inputs beat the shadow.
    always_comb begin
        commit_now  = vblank_start && (upd_sysregs || state == PENDING);
        commit_info = upd_sysregs ? BotInfo_in : shadow_info;
        moving      = commit_now ? bot_moving(commit_info) : bot_moving(info);
    end

    // Shadow/commit FSM with registered display-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            shadow_x     <= '0;
            shadow_y     <= '0;
            shadow_info  <= 8'd0;
            loc_x        <= '0;
            loc_y        <= '0;
            info         <= 8'd0;
            commit_pulse <= 1'b0;
            overrun_cnt  <= 8'd0;
        end else begin
            commit_pulse <= 1'b0;
            if (vblank_start && upd_sysregs) begin
                // Update coincides with vblank: bypass the shadow.
                loc_x        <= LocX_in;
                loc_y        <= LocY_in;
                info         <= BotInfo_in;
                commit_pulse <= 1'b1;
                state        <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (upd_sysregs) begin
                            shadow_x    <= LocX_in;
                            shadow_y    <= LocY_in;
                            shadow_info <= BotInfo_in;
                            state       <= PENDING;
                        end
                    end
                    PENDING: begin
                        if (vblank_start) begin
                            loc_x        <= shadow_x;
                            loc_y        <= shadow_y;
                            info         <= shadow_info;
                            commit_pulse <= 1'b1;
                            state        <= IDLE;
                        end else if (upd_sysregs) begin
                            // Latest update wins; the dropped one is counted.
                            shadow_x    <= LocX_in;
                            shadow_y    <= LocY_in;
                            shadow_info <= BotInfo_in;
                            if (overrun_cnt != 8'hFF)
                                overrun_cnt <= overrun_cnt + 8'd1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    bot_reg_sync_anim_seq #(
        .ANIM_FRAMES (ANIM_FRAMES)
    ) u_anim (
        .clk       (clk),
        .reset     (reset),
        .step_en   (vblank_start),
        .moving    (moving),
        .frame_col (col)
    );

    assign LocX_reg    = 32'(loc_x);
    assign LocY_reg    = 32'(loc_y);
    assign BotInfo_reg = info;
    assign frame_col   = 32'(col);

endmodule

// File: tb/tb_bot_reg_sync.sv
// Directed bench for bot_reg_sync: per-frame vector table plus hand-written
// sequences for reset, coincident update/vblank and overrun saturation.
module tb_bot_reg_sync;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [31:0] pixel_row = 32'sd800;
    logic               upd_sysregs = 1'b0;
    logic [7:0]         LocX_in = 8'd0;
    logic [7:0]         LocY_in = 8'd0;
    logic [7:0]         BotInfo_in = 8'd0;
    logic signed [31:0] LocX_reg;
    logic signed [31:0] LocY_reg;
    logic [7:0]         BotInfo_reg;
    logic signed [31:0] frame_col;
    logic               commit_pulse;
    logic [7:0]         overrun_cnt;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_x = 8'd0;

    bot_reg_sync #(
        .V_ACTIVE    (768),
        .ANIM_FRAMES (2),
        .LOC_W       (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pixel_row    (pixel_row),
        .upd_sysregs  (upd_sysregs),
        .LocX_in      (LocX_in),
        .LocY_in      (LocY_in),
        .BotInfo_in   (BotInfo_in),
        .LocX_reg     (LocX_reg),
        .LocY_reg     (LocY_reg),
        .BotInfo_reg  (BotInfo_reg),
        .frame_col    (frame_col),
        .commit_pulse (commit_pulse),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n_upd;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] info;
        logic [7:0] ex;
        logic [7:0] ey;
        logic [7:0] einfo;
        logic       epulse;
        logic [7:0] eovr;
        int         ecol;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One video frame: optional update burst mid-frame, then vblank entry.
    task automatic run_frame(input int idx, input vec_t v);
        pixel_row = 32'sd100;
        tick();
        for (int k = 0; k < v.n_upd; k++) begin
            upd_sysregs = 1'b1;
            LocX_in     = v.x + 8'(k);
            LocY_in     = v.y;
            BotInfo_in  = v.info;
            tick();
        end
        upd_sysregs = 1'b0;
        pixel_row = 32'sd767;
        tick();
        chk($sformatf("v%0d_hold_x", idx), LocX_reg, {24'd0, last_x});
        pixel_row = 32'sd768;
        tick();
        chk($sformatf("v%0d_x", idx), LocX_reg, {24'd0, v.ex});
        chk($sformatf("v%0d_y", idx), LocY_reg, {24'd0, v.ey});
        chk($sformatf("v%0d_info", idx), {24'd0, BotInfo_reg}, {24'd0, v.einfo});
        chk($sformatf("v%0d_pulse", idx), {31'd0, commit_pulse}, {31'd0, v.epulse});
        chk($sformatf("v%0d_ovr", idx), {24'd0, overrun_cnt}, {24'd0, v.eovr});
        chk($sformatf("v%0d_col", idx), frame_col, 32'(v.ecol));
        last_x = v.ex;
        pixel_row = 32'sd0;
        tick();
        chk($sformatf("v%0d_pulse_off", idx), {31'd0, commit_pulse}, 32'd0);
    endtask

    initial begin
        //            n  x      y      info   ex     ey     einfo  pls  ovr   col
        tbl[0]  = '{1, 8'h40, 8'h20, 8'h00, 8'h40, 8'h20, 8'h00, 1'b1, 8'd0, 1};
        tbl[1]  = '{3, 8'h01, 8'h05, 8'h00, 8'h03, 8'h05, 8'h00, 1'b1, 8'd2, 1};
        tbl[2]  = '{0, 8'h00, 8'h00, 8'h00, 8'h03, 8'h05, 8'h00, 1'b0, 8'd2, 1};
        tbl[3]  = '{1, 8'h10, 8'h11, 8'h32, 8'h10, 8'h11, 8'h32, 1'b1, 8'd2, 1};
        tbl[4]  = '{0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h32, 1'b0, 8'd2, 2};
        tbl[5]  = '{0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h32, 1'b0, 8'd2, 2};
        tbl[6]  = '{0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h32, 1'b0, 8'd2, 1};
        tbl[7]  = '{0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h32, 1'b0, 8'd2, 1};
        tbl[8]  = '{0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h32, 1'b0, 8'd2, 0};
        tbl[9]  = '{0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h32, 1'b0, 8'd2, 0};
        tbl[10] = '{0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h32, 1'b0, 8'd2, 1};
        tbl[11] = '{0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h32, 1'b0, 8'd2, 1};
        tbl[12] = '{0, 8'h00, 8'h00, 8'h00, 8'h10, 8'h11, 8'h32, 1'b0, 8'd2, 2};
        tbl[13] = '{1, 8'h20, 8'h21, 8'h02, 8'h20, 8'h21, 8'h02, 1'b1, 8'd2, 1};
        tbl[14] = '{0, 8'h00, 8'h00, 8'h00, 8'h20, 8'h21, 8'h02, 1'b0, 8'd2, 1};

        // Reset values, with the row held inside vblank across release.
        tick();
        tick();
        chk("rst_x", LocX_reg, 32'd0);
        chk("rst_y", LocY_reg, 32'd0);
        chk("rst_info", {24'd0, BotInfo_reg}, 32'd0);
        chk("rst_col", frame_col, 32'd1);
        chk("rst_pulse", {31'd0, commit_pulse}, 32'd0);
        chk("rst_ovr", {24'd0, overrun_cnt}, 32'd0);
        reset = 1'b0;
        upd_sysregs = 1'b1;
        LocX_in = 8'h77;
        tick();
        upd_sysregs = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("vb_hold_pulse", {31'd0, commit_pulse}, 32'd0);
            tick();
        end
        chk("vb_hold_x", LocX_reg, 32'd0);
        pixel_row = 32'sd0;
        tick();
        pixel_row = 32'sd768;
        tick();
        chk("vb_first_x", LocX_reg, 32'h77);
        chk("vb_first_pulse", {31'd0, commit_pulse}, 32'd1);
        pixel_row = 32'sd0;
        tick();

        // Reset while an update is pending discards it.
        pixel_row = 32'sd100;
        upd_sysregs = 1'b1;
        LocX_in = 8'h99;
        tick();
        upd_sysregs = 1'b0;
        tick();
        #2 reset = 1'b1;
        #1;
        chk("midrst_x", LocX_reg, 32'd0);
        chk("midrst_col", frame_col, 32'd1);
        chk("midrst_pulse", {31'd0, commit_pulse}, 32'd0);
        tick();
        reset = 1'b0;
        pixel_row = 32'sd767;
        tick();
        pixel_row = 32'sd768;
        tick();
        chk("midrst_no_commit", {31'd0, commit_pulse}, 32'd0);
        chk("midrst_x_after", LocX_reg, 32'd0);
        pixel_row = 32'sd0;
        tick();
        last_x = 8'd0;

        // Per-frame vector table.
        for (int i = 0; i < 15; i++)
            run_frame(i, tbl[i]);

        // Update coincident with vblank while PENDING: inputs win, no overrun.
        pixel_row = 32'sd100;
        upd_sysregs = 1'b1;
        LocX_in = 8'h11;
        LocY_in = 8'h12;
        BotInfo_in = 8'h00;
        tick();
        upd_sysregs = 1'b0;
        pixel_row = 32'sd767;
        tick();
        chk("sim_hold_x", LocX_reg, 32'h20);
        pixel_row = 32'sd768;
        upd_sysregs = 1'b1;
        LocX_in = 8'h55;
        LocY_in = 8'h56;
        tick();
        upd_sysregs = 1'b0;
        chk("sim_x", LocX_reg, 32'h55);
        chk("sim_y", LocY_reg, 32'h56);
        chk("sim_pulse", {31'd0, commit_pulse}, 32'd1);
        chk("sim_ovr", {24'd0, overrun_cnt}, 32'd2);
        pixel_row = 32'sd0;
        tick();
        pixel_row = 32'sd768;
        tick();
        chk("sim_idle_pulse", {31'd0, commit_pulse}, 32'd0);
        chk("sim_idle_x", LocX_reg, 32'h55);
        pixel_row = 32'sd0;
        tick();

        // Overrun counter saturation.
        pixel_row = 32'sd100;
        for (int i = 0; i <= 300; i++) begin
            upd_sysregs = 1'b1;
            LocX_in = 8'(i);
            tick();
            if (i == 200)
                chk("ovr_mid", {24'd0, overrun_cnt}, 32'd202);
        end
        upd_sysregs = 1'b0;
        chk("ovr_sat", {24'd0, overrun_cnt}, 32'd255);
        pixel_row = 32'sd768;
        tick();
        chk("ovr_commit_x", LocX_reg, 32'h2C);
        chk("ovr_sat_hold", {24'd0, overrun_cnt}, 32'd255);
        pixel_row = 32'sd0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
